ps2_receiver: RTL

PS2_RECEIVER -- requirements
Module: ps2_receiver

---
 rtl/ps2_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit
// frames with odd parity, and queues good scan codes in a small FIFO.
module ps2_receiver #(
    parameter int TIMEOUT_CYCLES = 12000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t        state;
    logic [1:0]    clk_sy;
    logic [1:0]    dat_sy;
    logic          clk_prev;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit;
    logic [TW-1:0] tcnt;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic fall;
    logic bit_in;
    logic par_ok;
    logic timeout;
    logic push;
    logic pop;
    logic full;
    logic wr_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_sy   <= 2'b11;
            dat_sy   <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sy   <= {clk_sy[0], ps2_clk};
            dat_sy   <= {dat_sy[0], ps2_data};
            clk_prev <= clk_sy[1];
        end
    end

    assign fall    = clk_prev & ~clk_sy[1];
    assign bit_in  = dat_sy[1];
    assign par_ok  = ^{shift, par_bit};
    assign timeout = (state != IDLE) && !fall &&
                     (tcnt == TW'(TIMEOUT_CYCLES - 1));
    assign push    = (state == STOP) && fall && bit_in && par_ok;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            par_bit    <= 1'b0;
            tcnt       <= '0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout) begin
                state     <= IDLE;
                tcnt      <= '0;
                frame_err <= 1'b1;
            end else begin
                if (state == IDLE || fall)
                    tcnt <= '0;
                else
                    tcnt <= tcnt + TW'(1);
                if (fall) begin
                    unique case (state)
                        IDLE: begin
                            bit_cnt <= 3'd0;
                            if (!bit_in)
                                state <= DATA;
                            else
                                frame_err <= 1'b1;
                        end
                        DATA: begin
                            shift   <= {bit_in, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par_bit <= bit_in;
                            state   <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            if (!bit_in)
                                frame_err <= 1'b1;
                            else if (!par_ok)
                                parity_err <= 1'b1;
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

    assign code_valid = (count != '0);
    assign code       = mem[rd_ptr];
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = code_valid & code_ready;
    // When full, a same-cycle pop frees the head slot that wr_ptr aliases
    assign wr_en      = push & (~full | pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 8'h00;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push & full & ~pop;
            if (wr_en) begin
                mem[wr_ptr] <= shift;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
